// File: rtl/cv32e41s_dummy_lfsr_ctrl.sv
// LFSR sequencer for dummy/hint instruction generation: shift scheduling with a
// saturating pending queue, CSR seeding with zero-seed recovery, counter-reset pulse.
module cv32e41s_dummy_lfsr_ctrl #(
    parameter logic [31:0] LFSR_TAPS         = 32'h8000_0057,
    parameter logic [31:0] LFSR_DEFAULT_SEED = 32'hACE1_2468,
    parameter int unsigned PEND_MAX          = 3,
    localparam int unsigned PEND_W           = $clog2(PEND_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seed_we_i,
    input  logic [31:0]       seed_wdata_i,
    input  logic              cpuctrl_we_i,
    input  logic              shift_dummy_i,
    input  logic              shift_hint_i,
    output logic [31:0]       lfsr_o,
    output logic              cntrst_o,
    output logic              lockup_o,
    output logic [PEND_W-1:0] pend_o,
    output logic              overflow_o
);

    localparam int unsigned TW = PEND_W + 1;

    logic [31:0]       lfsr_q, lfsr_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              cntrst_q, cntrst_d;
    logic              lockup_q, lockup_d;
    logic [1:0]        req;
    logic [TW-1:0]     total;

    function automatic logic [31:0] lfsr_step(input logic [31:0] q);
        return (q >> 1) ^ (q[0] ? LFSR_TAPS : 32'h0);
    endfunction

    always_comb begin
        req      = {1'b0, shift_dummy_i} + {1'b0, shift_hint_i};
        total    = {1'b0, pend_q} + TW'(req);
        lfsr_d   = lfsr_q;
        pend_d   = pend_q;
        ovf_d    = ovf_q;
        lockup_d = 1'b0;
        cntrst_d = seed_we_i | cpuctrl_we_i;

        // A seed write wins outright: queued and same-cycle shifts are dropped silently.
        if (seed_we_i) begin
            lockup_d = (seed_wdata_i == '0);
            lfsr_d   = lockup_d ? LFSR_DEFAULT_SEED : seed_wdata_i;
            pend_d   = '0;
        end else if (total != '0) begin
            lfsr_d = lfsr_step(lfsr_q);
            if (total > TW'(PEND_MAX + 1)) begin
                pend_d = PEND_W'(PEND_MAX);
                ovf_d  = 1'b1;
            end else begin
                pend_d = PEND_W'(total - TW'(1));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q   <= LFSR_DEFAULT_SEED;
            pend_q   <= '0;
            ovf_q    <= 1'b0;
            cntrst_q <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            lfsr_q   <= lfsr_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            cntrst_q <= cntrst_d;
            lockup_q <= lockup_d;
        end
    end

    assign lfsr_o     = lfsr_q;
    assign pend_o     = pend_q;
    assign overflow_o = ovf_q;
    assign cntrst_o   = cntrst_q;
    assign lockup_o   = lockup_q;

endmodule

// File: doc/cv32e41s_dummy_lfsr_ctrl.md
Name: cv32e41s_dummy_lfsr_ctrl

Overview:
- Owns and sequences the LFSR that drives dummy and hint instruction generation: instruction type, rs1/rs2, and insertion interval.
- Schedules shift requests from the dummy and hint retire paths, at most one shift per cycle, queuing the surplus.
- Applies CSR seed writes and detects zero-seed lockup.
- Emits a one-cycle counter-reset pulse so the dummy insertion counter restarts after any configuration change. Sits inside the xsecure control logic; its outputs feed the lfsr0 and cntrst fields consumed by the dummy instruction generator.

Parameters:
- LFSR_TAPS, 32'h8000_0057, Galois feedback polynomial mask; bit 31 must be set.
- LFSR_DEFAULT_SEED, 32'hACE1_2468, seed loaded at reset and on zero-seed lockup recovery; must be nonzero.
- PEND_MAX, 3, saturation value of the pending-shift counter; width is $clog2(PEND_MAX+1).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- seed_we_i  in  1  CSR write strobe for the LFSR seed
- seed_wdata_i  in  32  seed value
- cpuctrl_we_i  in  1  CSR write strobe for cpuctrl (rnddummy/rnddummyfreq)
- shift_dummy_i  in  1  dummy instruction left ID; request one shift
- shift_hint_i  in  1  hint instruction left ID; request one shift
- lfsr_o  out  32  current LFSR state (registered)
- cntrst_o  out  1  one-cycle pulse; resets the dummy insertion counter
- lockup_o  out  1  one-cycle pulse; zero seed was replaced by the default seed
- pend_o  out  2  pending-shift count (registered)
- overflow_o  out  1  sticky; a shift request was dropped due to saturation

Behaviour:
- Reset values: lfsr_q=LFSR_DEFAULT_SEED, pend_q=0, cntrst_o=0, lockup_o=0, overflow_o=0.
- Shift function: next = (q>>1) ^ (q[0] ? LFSR_TAPS : 32'h0).
- Per-cycle request count: r = shift_dummy_i + shift_hint_i (0..2). Total t = pend_q + r.
- Scheduling when no seed write: if t>0, perform exactly one shift this cycle.
  - pend_next = min(t-1, PEND_MAX).
  - If t-1 > PEND_MAX, set overflow_o (sticky until reset).
  - If t=0, lfsr_q holds.
- Shift is applied on the clock edge, so lfsr_o reflects a request one cycle after it is presented. Queued shifts drain at one per cycle.
- Seed write (seed_we_i=1) has priority over all shifts:
  - lfsr_q <= seed_wdata_i, or LFSR_DEFAULT_SEED if seed_wdata_i==0.
  - pend_q <= 0; same-cycle shift requests are discarded, not counted as overflow.
  - lockup_o=1 the next cycle iff seed_wdata_i==0.
- cntrst_o: registered; equals 1 in the cycle after any cycle with seed_we_i or cpuctrl_we_i. Back-to-back writes give back-to-back pulses, not stretched or merged.
- cpuctrl_we_i alone does not alter lfsr_q or pend_q.
- Invariant: lfsr_q is never 0. The polynomial has bit 31 set and a zero seed is substituted, so the lockup path is the only zero-recovery mechanism.
- Reset mid-operation: all state returns to reset values asynchronously; pending shifts are lost and no cntrst/lockup pulse is generated on reset release.
- No combinational path from inputs to outputs.

Test Plan:
- Reset release, no stimulus -> lfsr_o=32'hACE1_2468, pend_o=0, cntrst_o=0, overflow_o=0 for 10 cycles.
- Seed write 32'h1, then shift_dummy_i one cycle -> lfsr_o=32'h1, then 32'h8000_0057. Second shift -> 32'hC000_007C. cntrst_o=1 exactly the one cycle after the write.
- Seed 32'h1; shift_dummy_i and shift_hint_i together for one cycle -> pend_o=1 next cycle, lfsr_o=32'h8000_0057. Following cycle: pend_o=0, lfsr_o=32'hC000_007C.
- Both shift inputs held high 4 cycles -> pend_o steps 1,2,3,3; overflow_o asserts on the 4th cycle's update and stays high; drain then takes 3 cycles at one shift each.
- Seed write 32'h0 concurrent with shift_hint_i, pend_o=2 -> lfsr_o=32'hACE1_2468, pend_o=0, lockup_o=1 and cntrst_o=1 for one cycle, overflow_o unchanged.
- cpuctrl_we_i on two consecutive cycles with pend_o=1 -> cntrst_o high two cycles; lfsr_o still performs its pending shift and pend_o reaches 0.
